sa_feed_ctrl: RTL and testbench

Parametrised sequencer that feeds the N×N systolic MAC array. It holds host-written weight and activation buffers. On `start` it loads the weights, streams skewed activations, drains the pipeline, captures the accumulators, and reports a selectable, optionally saturated result lane. It replaces the hard-coded per-state weight/activation tables in the top level and sits between the board-level control and the array instance.

---
 rtl/sa_pkg.sv | 34 +++
 rtl/sa_feed_ctrl_if.sv | 47 ++++
 rtl/sa_skew_buf.sv | 70 +++++++
 rtl/sa_feed_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_sa_feed_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array feed controller.
//   sa_state_e : run sequencer states
//   lane_lsb   : bit offset of lane `lane` in a packed vector of `width`-bit lanes
//   sat_lane   : unsigned saturate-or-truncate of an accumulator lane to `dw` bits
package sa_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    STREAM  = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4
  } sa_state_e;

  // Widest accumulator lane the saturation helper handles.
  localparam int SAT_W = 64;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // Accumulators are unsigned, so anything above 2^dw-1 clips to all ones.
  function automatic logic [SAT_W-1:0] sat_lane(input logic [SAT_W-1:0] lane,
                                                input int dw,
                                                input logic sat_en);
    logic [SAT_W-1:0] max_val;
    max_val = (SAT_W'(1) << dw) - SAT_W'(1);
    if (sat_en && (lane > max_val)) begin
      return max_val;
    end
    return lane & max_val;
  endfunction

endpackage

// File: rtl/sa_feed_ctrl_if.sv
// Bus bundle between host/array side and the feed controller.
//   Host -> ctrl : start, k_len, w_we/w_addr/w_data, a_we/a_addr/a_data,
//                  c_in (array column accumulators), c_sel, sat_en
//   Ctrl -> host : w_out, a_out, hold (to array), busy, done, wr_err, result
// Modports: master = host/array side, slave = sa_feed_ctrl.
interface sa_feed_ctrl_if #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 24,
  parameter int K_MAX = 16
);
  localparam int K_W  = $clog2(K_MAX + 1);
  localparam int WA_W = $clog2(N);
  localparam int AA_W = $clog2(K_MAX);

  logic                 start;
  logic [K_W-1:0]       k_len;
  logic                 w_we;
  logic [WA_W-1:0]      w_addr;
  logic [N*DW-1:0]      w_data;
  logic                 a_we;
  logic [AA_W-1:0]      a_addr;
  logic [N*DW-1:0]      a_data;
  logic [N*ACC_W-1:0]   c_in;
  logic [WA_W-1:0]      c_sel;
  logic                 sat_en;
  logic [N*DW-1:0]      w_out;
  logic [N*DW-1:0]      a_out;
  logic                 hold;
  logic                 busy;
  logic                 done;
  logic                 wr_err;
  logic [DW-1:0]        result;

  modport master (
    output start, k_len, w_we, w_addr, w_data, a_we, a_addr, a_data,
           c_in, c_sel, sat_en,
    input  w_out, a_out, hold, busy, done, wr_err, result
  );

  modport slave (
    input  start, k_len, w_we, w_addr, w_data, a_we, a_addr, a_data,
           c_in, c_sel, sat_en,
    output w_out, a_out, hold, busy, done, wr_err, result
  );

endinterface

// File: rtl/sa_skew_buf.sv
// Activation storage (K_MAX vectors of N lanes) with diagonally skewed readout.
//   we/addr/wdata : vector write (caller already gates it to idle)
//   stream_en     : the next cycle is a STREAM cycle
//   t             : stream step for the next cycle
//   k_q           : vectors in this run
//   a_out         : registered skewed activations; lane j = abuf[t-j][j] or 0
module sa_skew_buf
  import sa_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int K_MAX = 16,
  parameter int CW    = 5,
  parameter int K_W   = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [$clog2(K_MAX)-1:0]   addr,
  input  logic [N*DW-1:0]            wdata,
  input  logic                       stream_en,
  input  logic [CW-1:0]              t,
  input  logic [K_W-1:0]             k_q,
  output logic [N*DW-1:0]            a_out
);
  localparam int AA_W = $clog2(K_MAX);

  logic [N*DW-1:0] abuf_reg [K_MAX];
  logic [DW-1:0]   lane_val [N];
  logic [N*DW-1:0] a_out_next;
  logic [N*DW-1:0] a_out_reg;

  // Buffer contents are part of the reset state, so this is flop storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K_MAX; i++) begin
        abuf_reg[i] <= '0;
      end
    end else if (we) begin
      abuf_reg[addr] <= wdata;
    end
  end

  // Lane j lags lane 0 by j steps; outside its window it feeds zeros.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [CW-1:0] diff;
    logic          hit;
    assign diff = t - CW'(gi);
    assign hit  = stream_en && (t >= CW'(gi)) && (diff < CW'(k_q));
    assign lane_val[gi] = hit ? abuf_reg[AA_W'(diff)][lane_lsb(gi, DW) +: DW] : '0;
  end

  always_comb begin
    a_out_next = '0;
    for (int j = 0; j < N; j++) begin
      a_out_next[j*DW +: DW] = lane_val[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out_reg <= '0;
    end else begin
      a_out_reg <= a_out_next;
    end
  end

  assign a_out = a_out_reg;

endmodule

// File: rtl/sa_feed_ctrl.sv
// Run sequencer feeding an N x N weight-stationary systolic MAC array.
// Holds the weight rows, drives the IDLE/LOAD/STREAM/DRAIN/CAPTURE sequence,
// captures the column accumulators and presents one lane, truncated or
// saturated, on `result`.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sa_feed_ctrl_if slave (host writes, array I/O, status, result)
module sa_feed_ctrl
  import sa_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 24,
  parameter int K_MAX = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  sa_feed_ctrl_if.slave bus
);
  localparam int K_W  = $clog2(K_MAX + 1);
  localparam int WA_W = $clog2(N);
  // Counter spans both N-cycle phases and the k_q+N-1 stream phase.
  localparam int CW   = $clog2(K_MAX + N + 1);

  sa_state_e          state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [K_W-1:0]     k_q_reg, k_q_next;
  logic [K_W-1:0]     k_clamped;
  logic [CW-1:0]      stream_last;
  logic               idle;

  logic [N*DW-1:0]    wbuf_reg [N];
  logic [N*DW-1:0]    w_out_reg, w_out_next;
  logic               hold_reg, busy_reg, done_reg, wr_err_reg;
  logic [N*ACC_W-1:0] res_q_reg;
  logic [ACC_W-1:0]   lane_sel;
  logic [N*DW-1:0]    a_out_w;

  assign idle        = (state_reg == IDLE);
  assign k_clamped   = (bus.k_len > K_W'(K_MAX)) ? K_W'(K_MAX) : bus.k_len;
  assign stream_last = CW'(k_q_reg) + CW'(N - 2);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    k_q_next   = k_q_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = LOAD;
          cnt_next   = '0;
          k_q_next   = k_clamped;
        end
      end
      LOAD: begin
        if (cnt_reg == CW'(N - 1)) begin
          cnt_next   = '0;
          state_next = (k_q_reg == '0) ? DRAIN : STREAM;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      STREAM: begin
        if (cnt_reg == stream_last) begin
          cnt_next   = '0;
          state_next = DRAIN;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt_reg == CW'(N - 1)) begin
          cnt_next   = '0;
          state_next = CAPTURE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      CAPTURE: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // ---------------- weight buffer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        wbuf_reg[i] <= '0;
      end
    end else if (bus.w_we && idle) begin
      wbuf_reg[bus.w_addr] <= bus.w_data;
    end
  end

  // Outputs are registered from the next state so they line up with the
  // state they belong to. Row N-1 is shifted in first.
  always_comb begin
    w_out_next = '0;
    if (state_next == LOAD) begin
      w_out_next = wbuf_reg[WA_W'(N - 1) - WA_W'(cnt_next)];
    end
  end

  // ---------------- datapath / status registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      k_q_reg    <= '0;
      w_out_reg  <= '0;
      hold_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      wr_err_reg <= 1'b0;
      res_q_reg  <= '0;
    end else begin
      cnt_reg   <= cnt_next;
      k_q_reg   <= k_q_next;
      w_out_reg <= w_out_next;
      // Array stays in compute mode through CAPTURE so the accumulators
      // are not disturbed while they are sampled.
      hold_reg  <= (state_next == STREAM) || (state_next == DRAIN) ||
                   (state_next == CAPTURE);
      busy_reg  <= (state_next != IDLE);
      done_reg  <= (state_reg == CAPTURE);
      if (idle && bus.start) begin
        wr_err_reg <= 1'b0;
      end else if (!idle && (bus.w_we || bus.a_we)) begin
        wr_err_reg <= 1'b1;
      end
      if (state_reg == CAPTURE) begin
        res_q_reg <= bus.c_in;
      end
    end
  end

  // ---------------- activation buffer ----------------
  sa_skew_buf #(
    .N     (N),
    .DW    (DW),
    .K_MAX (K_MAX),
    .CW    (CW),
    .K_W   (K_W)
  ) u_skew (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (bus.a_we && idle),
    .addr      (bus.a_addr),
    .wdata     (bus.a_data),
    .stream_en (state_next == STREAM),
    .t         (cnt_next),
    .k_q       (k_q_reg),
    .a_out     (a_out_w)
  );

  // ---------------- readout ----------------
  assign lane_sel   = res_q_reg[lane_lsb(int'(bus.c_sel), ACC_W) +: ACC_W];
  assign bus.result = DW'(sat_lane(SAT_W'(lane_sel), DW, bus.sat_en));

  assign bus.w_out  = w_out_reg;
  assign bus.a_out  = a_out_w;
  assign bus.hold   = hold_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.wr_err = wr_err_reg;

endmodule

// File: tb/tb_sa_feed_ctrl.sv
// Self-checking bench for sa_feed_ctrl: cycle-by-cycle comparison of every
// registered output against a timeline derived from run length, plus a
// readout check of every lane in both modes after each run.
module tb_sa_feed_ctrl;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int ACC_W = 24;
  localparam int K_MAX = 16;
  localparam int K_W   = $clog2(K_MAX + 1);
  localparam int WA_W  = $clog2(N);
  localparam int AA_W  = $clog2(K_MAX);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [N*DW-1:0] wbuf_m [N];
  logic [N*DW-1:0] abuf_m [K_MAX];

  sa_feed_ctrl_if #(.N(N), .DW(DW), .ACC_W(ACC_W), .K_MAX(K_MAX)) bus ();

  sa_feed_ctrl #(.N(N), .DW(DW), .ACC_W(ACC_W), .K_MAX(K_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Weight-stationary product: column j = sum over vectors t and rows i of a_t[i]*W[i][j].
  function automatic logic [N*ACC_W-1:0] golden(input int k);
    logic [N*ACC_W-1:0] c;
    int s;
    c = '0;
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int t = 0; t < k; t++)
        for (int i = 0; i < N; i++)
          s += int'(abuf_m[t][i*DW +: DW]) * int'(wbuf_m[i][j*DW +: DW]);
      c[j*ACC_W +: ACC_W] = ACC_W'(s);
    end
    return c;
  endfunction

  function automatic logic [DW-1:0] exp_result(input logic [N*ACC_W-1:0] c, input int sel, input int sat);
    longint lane;
    longint maxv;
    lane = longint'(c[sel*ACC_W +: ACC_W]);
    maxv = (longint'(1) << DW) - 1;
    if (sat != 0 && lane > maxv) return DW'(maxv);
    return DW'(lane % (maxv + 1));
  endfunction

  function automatic logic [N*DW-1:0] rand_vec();
    logic [N*DW-1:0] v;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < N; i++) wbuf_m[i] = '0;
    for (int i = 0; i < K_MAX; i++) abuf_m[i] = '0;
  endfunction

  // ---------------- drivers ----------------
  task automatic write_w(input int r, input logic [N*DW-1:0] d);
    bus.w_we = 1'b1; bus.w_addr = WA_W'(r); bus.w_data = d;
    @(posedge clk); #1;
    bus.w_we = 1'b0;
    wbuf_m[r] = d;
    @(negedge clk);
  endtask

  task automatic write_a(input int r, input logic [N*DW-1:0] d);
    bus.a_we = 1'b1; bus.a_addr = AA_W'(r); bus.a_data = d;
    @(posedge clk); #1;
    bus.a_we = 1'b0;
    abuf_m[r] = d;
    @(negedge clk);
  endtask

  task automatic fill_random();
    for (int r = 0; r < N; r++) write_w(r, rand_vec());
    for (int r = 0; r < K_MAX; r++) write_a(r, rand_vec());
  endtask

  // One run from the start edge through done. Called on a falling edge.
  // err_cycle > 0 pulses a_we in that cycle; rst_cycle > 0 pulls reset there.
  task automatic run_check(input int kl, input bit keep_start, input int err_cycle,
                           input int rst_cycle, input bit force_c,
                           input logic [N*ACC_W-1:0] c_force);
    int k, d, t, idx;
    logic [N*DW-1:0] exp_w, exp_a;
    logic exp_hold, exp_busy, exp_done, exp_err;
    logic [N*ACC_W-1:0] cval;
    k = (kl > K_MAX) ? K_MAX : kl;
    d = (k == 0) ? 2*N + 2 : 3*N + k + 1;
    cval = force_c ? c_force : golden(k);
    $display("run: k_len=%0d effective k=%0d expect done at cycle %0d", kl, k, d);
    bus.k_len = K_W'(kl);
    bus.c_in  = cval;
    bus.start = 1'b1;
    @(posedge clk); #1;
    if (!keep_start) bus.start = 1'b0;
    for (int c = 1; c <= d; c++) begin
      @(negedge clk);
      bus.a_we = 1'b0;
      if (c == rst_cycle) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.w_out, bus.a_out, bus.hold, bus.busy, bus.done, bus.wr_err, bus.result} !== '0) begin
          errors++;
          $display("FAIL async_reset cycle %0d: w_out=%h a_out=%h hold=%b busy=%b done=%b wr_err=%b result=%h, required all 0",
                   c, bus.w_out, bus.a_out, bus.hold, bus.busy, bus.done, bus.wr_err, bus.result);
        end
        clear_model();
        return;
      end
      exp_w = (c <= N) ? wbuf_m[N - c] : '0;
      exp_a = '0;
      if (k > 0 && c >= N + 1 && c <= 2*N + k - 1) begin
        t = c - N - 1;
        for (int j = 0; j < N; j++) begin
          idx = t - j;
          if (idx >= 0 && idx < k) exp_a[j*DW +: DW] = abuf_m[idx][j*DW +: DW];
        end
      end
      exp_hold = (c >= N + 1 && c <= d - 2);
      exp_busy = (c < d);
      exp_done = (c == d);
      exp_err  = (err_cycle > 0 && c > err_cycle);
      checks++;
      if (bus.w_out !== exp_w) begin
        errors++;
        $display("FAIL w_out cycle %0d: got %h required %h", c, bus.w_out, exp_w);
      end
      checks++;
      if (bus.a_out !== exp_a) begin
        errors++;
        $display("FAIL a_out cycle %0d: got %h required %h", c, bus.a_out, exp_a);
      end
      if (c != d - 1) begin
        checks++;
        if (bus.hold !== exp_hold) begin
          errors++;
          $display("FAIL hold cycle %0d: got %b required %b", c, bus.hold, exp_hold);
        end
      end
      checks++;
      if (bus.busy !== exp_busy) begin
        errors++;
        $display("FAIL busy cycle %0d: got %b required %b", c, bus.busy, exp_busy);
      end
      checks++;
      if (bus.done !== exp_done) begin
        errors++;
        $display("FAIL done cycle %0d: got %b required %b", c, bus.done, exp_done);
      end
      checks++;
      if (bus.wr_err !== exp_err) begin
        errors++;
        $display("FAIL wr_err cycle %0d: got %b required %b", c, bus.wr_err, exp_err);
      end
      if (c == err_cycle) begin
        bus.a_we = 1'b1; bus.a_addr = '0; bus.a_data = ~abuf_m[0];
      end
    end
    if (!keep_start) begin
      bus.c_in = ~cval;
      for (int sel = 0; sel < N; sel++) begin
        for (int sat = 0; sat < 2; sat++) begin
          bus.c_sel  = WA_W'(sel);
          bus.sat_en = (sat != 0);
          #1;
          checks++;
          if (bus.result !== exp_result(cval, sel, sat)) begin
            errors++;
            $display("FAIL result lane %0d sat %0d: got %h required %h",
                     sel, sat, bus.result, exp_result(cval, sel, sat));
          end
        end
      end
      bus.c_sel = '0; bus.sat_en = 1'b0;
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    checks++;
    if ({bus.w_out, bus.a_out, bus.hold, bus.busy, bus.done, bus.wr_err, bus.result} !== '0) begin
      errors++;
      $display("FAIL reset_state: w_out=%h a_out=%h hold=%b busy=%b done=%b wr_err=%b result=%h, required all 0",
               bus.w_out, bus.a_out, bus.hold, bus.busy, bus.done, bus.wr_err, bus.result);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_plan_vectors();
    logic [N*DW-1:0] v;
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'((r % 2 == 0) ? 4 - j : 8 - j);
      write_w(r, v);
    end
    for (int t = 0; t < 8; t++) begin
      for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(8 - t);
      write_a(t, v);
    end
    run_check(8, 1'b0, 0, 0, 1'b0, '0);
  endtask

  task automatic test_zero_k();
    run_check(0, 1'b0, 0, 0, 1'b0, '0);
  endtask

  task automatic test_clamp();
    fill_random();
    run_check(20, 1'b0, 0, 0, 1'b0, '0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      fill_random();
      run_check(int'($urandom_range(1, K_MAX)), 1'b0, 0, 0, 1'b0, '0);
    end
  endtask

  task automatic test_wr_err();
    run_check(8, 1'b0, 6, 0, 1'b0, '0);
    checks++;
    if (bus.wr_err !== 1'b1) begin
      errors++;
      $display("FAIL wr_err_sticky: got %b required 1", bus.wr_err);
    end
    run_check(8, 1'b0, 0, 0, 1'b0, '0);
  endtask

  task automatic test_dual_write();
    int wr, ar;
    logic [N*DW-1:0] wd, ad;
    wr = int'($urandom_range(0, N - 1));
    ar = int'($urandom_range(0, 5));
    wd = rand_vec();
    ad = rand_vec();
    bus.w_we = 1'b1; bus.w_addr = WA_W'(wr); bus.w_data = wd;
    bus.a_we = 1'b1; bus.a_addr = AA_W'(ar); bus.a_data = ad;
    @(posedge clk); #1;
    bus.w_we = 1'b0; bus.a_we = 1'b0;
    wbuf_m[wr] = wd;
    abuf_m[ar] = ad;
    @(negedge clk);
    run_check(6, 1'b0, 0, 0, 1'b0, '0);
  endtask

  task automatic test_saturation();
    logic [N*ACC_W-1:0] c;
    for (int j = 0; j < N; j++) c[j*ACC_W +: ACC_W] = ACC_W'($urandom_range(0, 600));
    c[2*ACC_W +: ACC_W] = ACC_W'(24'h000123);
    run_check(0, 1'b0, 0, 0, 1'b1, c);
    c[2*ACC_W +: ACC_W] = ACC_W'(24'h00007F);
    run_check(3, 1'b0, 0, 0, 1'b1, c);
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_check(5, 1'b1, 0, 0, 1'b0, '0);
    run_check(2, 1'b0, 0, 0, 1'b0, '0);
  endtask

  task automatic test_reset_mid();
    fill_random();
    run_check(8, 1'b0, 0, 7, 1'b0, '0);
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: busy=%b done=%b required 0 0", bus.busy, bus.done);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_check(4, 1'b0, 0, 0, 1'b0, '0);
    fill_random();
    run_check(7, 1'b0, 0, 0, 1'b0, '0);
  endtask

  initial begin
    bus.start = 1'b0; bus.k_len = '0;
    bus.w_we = 1'b0; bus.w_addr = '0; bus.w_data = '0;
    bus.a_we = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.c_in = '0; bus.c_sel = '0; bus.sat_en = 1'b0;
    clear_model();
    test_reset();
    test_plan_vectors();
    test_zero_k();
    test_clamp();
    test_random();
    test_wr_err();
    test_dual_write();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
